// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: FSM state encoding and the
//   default address/data widths used by the top-level parameters.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/arb_hold_reg.sv
// arb_hold_reg
//   Enable-gated holding register with synchronous active-low clear.
//   Ports:
//     clk   in   rising-edge clock
//     rst_n in   synchronous active-low reset (clears q)
//     load  in   capture d on the next edge
//     d     in   W-bit data to capture
//     q     out  W-bit held value
module arb_hold_reg
  import mem_arbiter_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold value until loaded; cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between the instruction side (port 0)
//   and the data side (port 1). Arbitrates in IDLE, latches the winner's
//   command, issues a single MemEn strobe, waits for MemDone and pulses
//   Done to the owner with the captured read data.
//
//   Build option: define ARB_RR_EN for round-robin tie breaking (port not
//   granted last wins a tie). Without it, port 1 wins every tie.
//
//   Ports:
//     clk, rst_n             clock, synchronous active-low reset
//     req0/1, wr0/1          request (held until done), 1 = write
//     addr0/1, wr_data0/1    per-port command
//     done0/1                one-cycle completion pulse to owner
//     rd_data                captured read data (valid with done)
//     busy                   arbiter not idle
//     mem_en, mem_wr         one-cycle access strobe, write enable
//     mem_addr, mem_wr_data  latched command towards memory
//     mem_rd_data, mem_done  memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AddrW = ADDR_W_DEF,
  parameter int DataW = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [AddrW-1:0] addr0,
  input  logic [AddrW-1:0] addr1,
  input  logic [DataW-1:0] wr_data0,
  input  logic [DataW-1:0] wr_data1,
  output logic             done0,
  output logic             done1,
  output logic [DataW-1:0] rd_data,
  output logic             busy,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [AddrW-1:0] mem_addr,
  output logic [DataW-1:0] mem_wr_data,
  input  logic [DataW-1:0] mem_rd_data,
  input  logic             mem_done
);

  // Command word layout: {wr, addr, wr_data, owner}
  localparam int CmdW = 1 + AddrW + DataW + 1;

  arb_state_t       state;
  arb_state_t       state_next;
  logic             any_req;
  logic             winner;
  logic             load_cmd;
  logic             load_rd;
  logic             owner;
  logic [CmdW-1:0]  cmd_d;
  logic [CmdW-1:0]  cmd_q;

  assign any_req  = req0 | req1;
  assign load_cmd = (state == IDLE) && any_req;
  assign load_rd  = ((state == ISSUE) || (state == WAIT)) && mem_done;

`ifdef ARB_RR_EN
  logic last_gnt;

  // Remember the most recent grant; reset value lets port 0 win the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (load_cmd) begin
      last_gnt <= winner;
    end else begin
      last_gnt <= last_gnt;
    end
  end

  // Round-robin pick: on a tie the port not granted last time wins
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else begin
      winner = req1;
    end
  end
`else
  // Fixed priority: port 1 wins a tie, a lone requester always wins
  always_comb begin
    winner = req1;
  end
`endif

  // Select the winner's command for the holding register
  always_comb begin
    cmd_d = {wr0, addr0, wr_data0, 1'b0};
    if (winner) begin
      cmd_d = {wr1, addr1, wr_data1, 1'b1};
    end else begin
      cmd_d = {wr0, addr0, wr_data0, 1'b0};
    end
  end

  arb_hold_reg #(.W(CmdW)) u_cmd_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_cmd),
    .d     (cmd_d),
    .q     (cmd_q)
  );

  arb_hold_reg #(.W(DataW)) u_rd_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_rd),
    .d     (mem_rd_data),
    .q     (rd_data)
  );

  assign {mem_wr, mem_addr, mem_wr_data, owner} = cmd_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; MemDone outside ISSUE/WAIT is ignored
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (mem_done) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from state and the holding registers
  always_comb begin
    busy   = (state != IDLE);
    mem_en = (state == ISSUE);
    done0  = (state == RESP) && !owner;
    done1  = (state == RESP) && owner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a table of single transactions,
//   hand-written multi-cycle corner cases, and a randomized run against a
//   transaction-level timing model. Honours ARB_RR_EN for tie expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [15:0] addr0, addr1, wr_data0, wr_data1;
  logic        done0, done1;
  logic [15:0] rd_data;
  logic        busy, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_done;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.AddrW(16), .DataW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .done0(done0), .done1(done1), .rd_data(rd_data), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Inputs change 1 time unit after the active edge; checks happen at negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wr_data0 = 16'h0000; wr_data1 = 16'h0000;
    mem_done = 1'b0; mem_rd_data = 16'h0000;
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    int          lat;      // cycles from MemEn to MemDone (0 = same cycle)
    logic [15:0] rdat;
    logic        exp_own;
  } vec_t;

  vec_t tbl[7];

  // One full transaction; entered and left at the start of an IDLE cycle
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] ea, ed;
    logic        ew;
    ea = v.exp_own ? v.a1 : v.a0;
    ed = v.exp_own ? v.d1 : v.d0;
    ew = v.exp_own ? v.w1 : v.w0;
    req0 = v.r0; req1 = v.r1; wr0 = v.w0; wr1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wr_data0 = v.d0; wr_data1 = v.d1;
    mem_done = 1'b0;
    @(negedge clk);
    chk1($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    next_cycle();
    if (v.lat == 0) begin
      mem_done = 1'b1; mem_rd_data = v.rdat;
    end
    @(negedge clk);
    chk1($sformatf("v%0d_issue_en", idx), mem_en, 1'b1);
    chk16($sformatf("v%0d_issue_addr", idx), mem_addr, ea);
    chk1($sformatf("v%0d_issue_wr", idx), mem_wr, ew);
    chk16($sformatf("v%0d_issue_wdata", idx), mem_wr_data, ed);
    chk1($sformatf("v%0d_issue_busy", idx), busy, 1'b1);
    for (int i = 1; i <= v.lat; i++) begin
      next_cycle();
      mem_done = (i == v.lat);
      mem_rd_data = (i == v.lat) ? v.rdat : 16'h0000;
      @(negedge clk);
      chk1($sformatf("v%0d_wait_en", idx), mem_en, 1'b0);
      chk16($sformatf("v%0d_wait_addr", idx), mem_addr, ea);
      chk1($sformatf("v%0d_wait_done0", idx), done0, 1'b0);
      chk1($sformatf("v%0d_wait_done1", idx), done1, 1'b0);
    end
    next_cycle();
    mem_done = 1'b0; mem_rd_data = 16'hDEAD;
    @(negedge clk);
    chk1($sformatf("v%0d_resp_done0", idx), done0, ~v.exp_own);
    chk1($sformatf("v%0d_resp_done1", idx), done1, v.exp_own);
    chk16($sformatf("v%0d_resp_rdata", idx), rd_data, v.rdat);
    chk1($sformatf("v%0d_resp_en", idx), mem_en, 1'b0);
    next_cycle();
  endtask

  // Transaction-level model state for the randomized run
  logic        pend[2];
  logic        p_wr[2];
  logic [15:0] p_addr[2];
  logic [15:0] p_wd[2];
  int          cool[2];
  logic        m_active;
  logic        t_own;
  int          t_issue, t_lat, t_done;
  logic [15:0] t_rdata;
`ifdef ARB_RR_EN
  logic        lgm;
`endif

  initial begin
    int   dcnt;
    logic w;

    tbl[0] = '{r0:1'b1, r1:1'b0, w0:1'b0, w1:1'b0, a0:16'h0040, a1:16'h0000,
               d0:16'h0000, d1:16'h0000, lat:3, rdat:16'hBEEF, exp_own:1'b0};
    tbl[1] = '{r0:1'b0, r1:1'b1, w0:1'b0, w1:1'b1, a0:16'h0000, a1:16'h0100,
               d0:16'h0000, d1:16'h1234, lat:0, rdat:16'h5A5A, exp_own:1'b1};
`ifdef ARB_RR_EN
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 1, 16'h0102, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 0, 16'h0304, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 2, 16'h0506, 1'b0};
`else
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 1, 16'h0102, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 0, 16'h0304, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h1111, 16'h2222, 2, 16'h0506, 1'b1};
`endif
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hCAFE, 16'h0000, 2, 16'h0F0F, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1, 16'h8001, 1'b1};

    // Reset state
    do_reset();
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_rd_data", rd_data, 16'h0000);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(tbl[k], k);

    // Port 1 requests while port 0's access is waiting
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0200; req1 = 1'b0; mem_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0300; wr_data1 = 16'h7777; end
      if (i == 4) begin mem_done = 1'b1; mem_rd_data = 16'hABCD; end
      if (i == 5) mem_done = 1'b0;
      if (i == 6) req0 = 1'b0;
      if (i == 7) mem_done = 1'b1;
      if (i == 8) begin mem_done = 1'b0; end
      @(negedge clk);
      chk1($sformatf("busyreq_en_c%0d", i), mem_en, (i == 1) || (i == 7));
      chk1($sformatf("busyreq_done0_c%0d", i), done0, i == 5);
      chk1($sformatf("busyreq_done1_c%0d", i), done1, i == 8);
      if (i == 5) chk16("busyreq_rdata", rd_data, 16'hABCD);
      if (i == 7) begin
        chk16("busyreq_p1_addr", mem_addr, 16'h0300);
        chk1("busyreq_p1_wr", mem_wr, 1'b1);
        chk16("busyreq_p1_wdata", mem_wr_data, 16'h7777);
      end
      next_cycle();
    end
    req1 = 1'b0;
    next_cycle();

    // Reset during WAIT aborts the access; a following tie is re-arbitrated
    req0 = 1'b1; addr0 = 16'h0600; addr1 = 16'h0700; wr0 = 1'b0; wr1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst_n = 1'b0;
      if (i == 3) begin rst_n = 1'b1; req1 = 1'b1; end
      if (i == 4) begin mem_done = 1'b1; mem_rd_data = 16'h2468; end
      if (i == 5) mem_done = 1'b0;
      if (i == 6) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      if (i == 3) begin
        chk1("rstwait_busy", busy, 1'b0);
        chk1("rstwait_en", mem_en, 1'b0);
        chk1("rstwait_done0", done0, 1'b0);
        chk1("rstwait_done1", done1, 1'b0);
        chk16("rstwait_addr", mem_addr, 16'h0000);
      end
      if (i == 4) begin
        chk1("rstwait_tie_en", mem_en, 1'b1);
`ifdef ARB_RR_EN
        chk16("rstwait_tie_addr", mem_addr, 16'h0600);
`else
        chk16("rstwait_tie_addr", mem_addr, 16'h0700);
`endif
      end
      next_cycle();
    end

    // Requester drops Req during WAIT; the access still completes
    dcnt = 0;
    req0 = 1'b1; req1 = 1'b0; addr0 = 16'h0440; wr0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) req0 = 1'b0;
      if (i == 3) begin mem_done = 1'b1; mem_rd_data = 16'h1357; end
      if (i == 4) mem_done = 1'b0;
      @(negedge clk);
      if (done0) dcnt++;
      chk1($sformatf("drop_done0_c%0d", i), done0, i == 4);
      if (i == 4) chk16("drop_rdata", rd_data, 16'h1357);
      next_cycle();
    end
    n_total++;
    if (dcnt == 1) n_pass++;
    else $display("FAIL drop_done_count: got %0d, expected 1", dcnt);

    // Randomized run against the transaction-level model
    do_reset();
    m_active = 1'b0;
`ifdef ARB_RR_EN
    lgm = 1'b1;
`endif
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; cool[p] = 0; p_wr[p] = 1'b0; p_addr[p] = 16'h0000; p_wd[p] = 16'h0000;
    end
    t_issue = 0; t_lat = 0; t_done = 0; t_own = 1'b0; t_rdata = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && cyc >= cool[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p]   = 1'b1;
          p_wr[p]   = 1'($urandom());
          p_addr[p] = 16'($urandom());
          p_wd[p]   = 16'($urandom());
        end
      end
      req0 = pend[0]; wr0 = p_wr[0]; addr0 = p_addr[0]; wr_data0 = p_wd[0];
      req1 = pend[1]; wr1 = p_wr[1]; addr1 = p_addr[1]; wr_data1 = p_wd[1];

      if (m_active && cyc == t_issue + t_lat) begin
        mem_done = 1'b1; mem_rd_data = t_rdata;
      end else if (m_active && cyc >= t_issue && cyc < t_issue + t_lat) begin
        mem_done = 1'b0; mem_rd_data = 16'($urandom());
      end else begin
        // Spurious MemDone while idle or responding must be ignored
        mem_done = 1'($urandom()); mem_rd_data = 16'($urandom());
      end

      if (!m_active && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) begin
`ifdef ARB_RR_EN
          w = ~lgm;
`else
          w = 1'b1;
`endif
        end else begin
          w = pend[1];
        end
`ifdef ARB_RR_EN
        lgm = w;
`endif
        m_active = 1'b1;
        t_own    = w;
        t_issue  = cyc + 1;
        t_lat    = $urandom_range(0, 3);
        t_done   = t_issue + t_lat + 1;
        t_rdata  = 16'($urandom());
      end

      @(negedge clk);
      chk1("rnd_mem_en", mem_en, m_active && cyc == t_issue);
      chk1("rnd_busy", busy, m_active && cyc >= t_issue);
      if (m_active && cyc >= t_issue) begin
        chk16("rnd_mem_addr", mem_addr, p_addr[t_own]);
        chk1("rnd_mem_wr", mem_wr, p_wr[t_own]);
        chk16("rnd_mem_wdata", mem_wr_data, p_wd[t_own]);
      end
      chk1("rnd_done0", done0, m_active && cyc == t_done && !t_own);
      chk1("rnd_done1", done1, m_active && cyc == t_done && t_own);
      if (m_active && cyc == t_done) begin
        chk16("rnd_rdata", rd_data, t_rdata);
        m_active    = 1'b0;
        pend[t_own] = 1'b0;
        cool[t_own] = cyc + 2;
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
